zx_kbd_matrix: RTL and testbench

PS/2 scancode-to-ZX-Spectrum keyboard matrix stage. It sits between the PS/2 receiver (byte plus one-cycle strobe) and the Z80 port 0xFE read mux. It decodes set-2 make/break/extended/pause sequences and tracks every mapped PC key independently. This fixes the shared-key problem: releasing "," never releases a physically held Symbol Shift. It answers row-select queries with the 5-bit active-low column value.

---
 rtl/zx_kbd_matrix.sv | 204 ++++++++++++++++++++
 tb/tb_zx_kbd_matrix.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/zx_kbd_matrix.sv
// zx_kbd_matrix
//   PS/2 set-2 scancode stream to ZX Spectrum 8x5 keyboard matrix.
//   Every mapped PC key has its own pressed flag, so keys that share a
//   matrix position (Symbol Shift, Caps Shift) are released only when no
//   PC key driving that position is still held.
// Ports:
//   clk          system clock (same domain as the PS/2 receiver)
//   reset        asynchronous active-high reset
//   ps2_data     received scancode byte
//   ps2_data_en  one-cycle byte strobe
//   row_sel      Z80 A15..A8, bit r low selects matrix row r
//   keys_out     column bits D4..D0, active low
//   any_key      registered, high while any mapped key is held
module zx_kbd_matrix #(
  parameter int unsigned TIMEOUT = 1_000_000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] ps2_data,
  input  logic       ps2_data_en,
  input  logic [7:0] row_sel,
  output logic [4:0] keys_out,
  output logic       any_key
);

  localparam int CW    = $clog2(TIMEOUT) + 1;
  localparam int NKEYS = 52;
  localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT - 1);

  typedef enum logic [2:0] {S_IDLE, S_BRK, S_EXT, S_EXT_BRK, S_PAUSE} state_t;

  // Returns {valid, flag index}. Indices 0..39 are single matrix positions
  // (row*5 + bit); 40..51 are PC keys that press two matrix positions.
  function automatic logic [6:0] decode(input logic ext, input logic [7:0] code);
    logic [6:0] r;
    r = '0;
    if (ext) begin
      case (code)
        8'h6B: r = {1'b1, 6'd48};
        8'h74: r = {1'b1, 6'd49};
        8'h75: r = {1'b1, 6'd50};
        8'h72: r = {1'b1, 6'd51};
        default: r = '0;
      endcase
    end else begin
      case (code)
        8'h12: r = {1'b1, 6'd0};  8'h1A: r = {1'b1, 6'd1};  8'h22: r = {1'b1, 6'd2};
        8'h21: r = {1'b1, 6'd3};  8'h2A: r = {1'b1, 6'd4};  8'h1C: r = {1'b1, 6'd5};
        8'h1B: r = {1'b1, 6'd6};  8'h23: r = {1'b1, 6'd7};  8'h2B: r = {1'b1, 6'd8};
        8'h34: r = {1'b1, 6'd9};  8'h15: r = {1'b1, 6'd10}; 8'h1D: r = {1'b1, 6'd11};
        8'h24: r = {1'b1, 6'd12}; 8'h2D: r = {1'b1, 6'd13}; 8'h2C: r = {1'b1, 6'd14};
        8'h16: r = {1'b1, 6'd15}; 8'h1E: r = {1'b1, 6'd16}; 8'h26: r = {1'b1, 6'd17};
        8'h25: r = {1'b1, 6'd18}; 8'h2E: r = {1'b1, 6'd19}; 8'h45: r = {1'b1, 6'd20};
        8'h46: r = {1'b1, 6'd21}; 8'h3E: r = {1'b1, 6'd22}; 8'h3D: r = {1'b1, 6'd23};
        8'h36: r = {1'b1, 6'd24}; 8'h4D: r = {1'b1, 6'd25}; 8'h44: r = {1'b1, 6'd26};
        8'h43: r = {1'b1, 6'd27}; 8'h3C: r = {1'b1, 6'd28}; 8'h35: r = {1'b1, 6'd29};
        8'h5A: r = {1'b1, 6'd30}; 8'h4B: r = {1'b1, 6'd31}; 8'h42: r = {1'b1, 6'd32};
        8'h3B: r = {1'b1, 6'd33}; 8'h33: r = {1'b1, 6'd34}; 8'h29: r = {1'b1, 6'd35};
        8'h59: r = {1'b1, 6'd36}; 8'h3A: r = {1'b1, 6'd37}; 8'h31: r = {1'b1, 6'd38};
        8'h32: r = {1'b1, 6'd39}; 8'h66: r = {1'b1, 6'd40}; 8'h41: r = {1'b1, 6'd41};
        8'h49: r = {1'b1, 6'd42}; 8'h4A: r = {1'b1, 6'd43}; 8'h4C: r = {1'b1, 6'd44};
        8'h52: r = {1'b1, 6'd45}; 8'h4E: r = {1'b1, 6'd46}; 8'h55: r = {1'b1, 6'd47};
        default: r = '0;
      endcase
    end
    return r;
  endfunction

  // Matrix positions pressed by a flag: {pos_a, pos_b}. CS = 0, SS = 36.
  function automatic logic [11:0] key_pos(input logic [5:0] idx);
    logic [11:0] p;
    case (idx)
      6'd40:   p = {6'd0,  6'd20};  // Backspace: CS+0
      6'd41:   p = {6'd36, 6'd38};  // ,  SS+N
      6'd42:   p = {6'd36, 6'd37};  // .  SS+M
      6'd43:   p = {6'd36, 6'd4};   // /  SS+V
      6'd44:   p = {6'd36, 6'd26};  // ;  SS+O
      6'd45:   p = {6'd36, 6'd25};  // '  SS+P
      6'd46:   p = {6'd36, 6'd33};  // -  SS+J
      6'd47:   p = {6'd36, 6'd31};  // =  SS+L
      6'd48:   p = {6'd0,  6'd19};  // left:  CS+5
      6'd49:   p = {6'd0,  6'd22};  // right: CS+8
      6'd50:   p = {6'd0,  6'd23};  // up:    CS+7
      6'd51:   p = {6'd0,  6'd24};  // down:  CS+6
      default: p = {idx, idx};
    endcase
    return p;
  endfunction

  state_t           state_q, state_d;
  logic [2:0]       skip_q, skip_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [NKEYS-1:0] flags_q, flags_d;
  logic [39:0]      mat_q, mat_d;
  logic             any_key_q, any_key_d;
  logic [7:0]       data_q, data_d;
  logic             strb_q, strb_d;
  logic [6:0]       dec;
  logic             fin, fin_brk;

  assign data_d = ps2_data;
  assign strb_d = ps2_data_en;
  assign dec    = decode(state_q == S_EXT || state_q == S_EXT_BRK, data_q);

  always_comb begin
    state_d = state_q;
    skip_d  = skip_q;
    cnt_d   = cnt_q;
    flags_d = flags_q;
    fin     = 1'b0;
    fin_brk = 1'b0;
    if (strb_q) begin
      cnt_d = '0;
      if (state_q != S_PAUSE &&
          (data_q == 8'hAA || data_q == 8'hFC || data_q == 8'h00 || data_q == 8'hFF)) begin
        flags_d = '0;
        state_d = S_IDLE;
      end else begin
        case (state_q)
          S_IDLE: begin
            if (data_q == 8'hF0)      state_d = S_BRK;
            else if (data_q == 8'hE0) state_d = S_EXT;
            else if (data_q == 8'hE1) begin
              state_d = S_PAUSE;
              skip_d  = 3'd7;
            end else fin = 1'b1;
          end
          S_BRK: begin
            fin     = 1'b1;
            fin_brk = 1'b1;
          end
          S_EXT: begin
            if (data_q == 8'hF0) state_d = S_EXT_BRK;
            else fin = 1'b1;
          end
          S_EXT_BRK: begin
            fin     = 1'b1;
            fin_brk = 1'b1;
          end
          S_PAUSE: begin
            skip_d = skip_q - 3'd1;
            if (skip_q == 3'd1) state_d = S_IDLE;
          end
          default: state_d = S_IDLE;
        endcase
      end
      if (fin) begin
        if (dec[6]) flags_d[dec[5:0]] = !fin_brk;
        state_d = S_IDLE;
      end
    end else if (state_q != S_IDLE) begin
      // Abandon a stale prefix; counter stays saturated until the next byte.
      if (cnt_q == TO_LAST) state_d = S_IDLE;
      else cnt_d = cnt_q + 1'b1;
    end
  end

  always_comb begin
    logic [11:0] p;
    p     = '0;
    mat_d = '1;
    for (int i = 0; i < NKEYS; i++) begin
      if (flags_q[i]) begin
        p = key_pos(i[5:0]);
        mat_d[p[11:6]] = 1'b0;
        mat_d[p[5:0]]  = 1'b0;
      end
    end
  end

  assign any_key_d = |flags_q;

  always_comb begin
    keys_out = '1;
    for (int r = 0; r < 8; r++) begin
      if (!row_sel[r]) keys_out = keys_out & mat_q[r*5 +: 5];
    end
  end

  assign any_key = any_key_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= S_IDLE;
      skip_q    <= '0;
      cnt_q     <= '0;
      flags_q   <= '0;
      mat_q     <= '1;
      any_key_q <= 1'b0;
      data_q    <= '0;
      strb_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      skip_q    <= skip_d;
      cnt_q     <= cnt_d;
      flags_q   <= flags_d;
      mat_q     <= mat_d;
      any_key_q <= any_key_d;
      data_q    <= data_d;
      strb_q    <= strb_d;
    end
  end

endmodule

// File: tb/tb_zx_kbd_matrix.sv
module tb_zx_kbd_matrix;

  localparam int TMO = 16;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] ps2_data;
  logic       ps2_data_en;
  logic [7:0] row_sel;
  logic [4:0] keys_out;
  logic       any_key;

  zx_kbd_matrix #(.TIMEOUT(TMO)) dut (
    .clk        (clk),
    .reset      (reset),
    .ps2_data   (ps2_data),
    .ps2_data_en(ps2_data_en),
    .row_sel    (row_sel),
    .keys_out   (keys_out),
    .any_key    (any_key)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] row;
    logic [4:0] keys;
    logic       any;
    string      name;
  } exp_t;

  exp_t exp_q[$];
  int   n_total = 0;
  int   n_bad   = 0;

  // Monitor: one queued expectation is compared on each falling edge.
  always @(negedge clk) begin
    exp_t e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n_total++;
      if (keys_out !== e.keys || any_key !== e.any) begin
        n_bad++;
        $display("FAIL %s row_sel=%h: got keys=%b any=%b, want keys=%b any=%b",
                 e.name, e.row, keys_out, any_key, e.keys, e.any);
      end
    end
  end

  task automatic check(input logic [7:0] r, input logic [4:0] k, input logic a, input string nm);
    exp_t e;
    row_sel = r;
    e.row = r; e.keys = k; e.any = a; e.name = nm;
    exp_q.push_back(e);
    @(negedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] b);
    @(posedge clk); #1;
    ps2_data = b; ps2_data_en = 1'b1;
    @(posedge clk); #1;
    ps2_data_en = 1'b0;
  endtask

  task automatic burst2(input logic [7:0] b0, input logic [7:0] b1);
    @(posedge clk); #1;
    ps2_data = b0; ps2_data_en = 1'b1;
    @(posedge clk); #1;
    ps2_data = b1;
    @(posedge clk); #1;
    ps2_data_en = 1'b0;
  endtask

  task automatic settle();
    repeat (3) @(posedge clk);
    #1;
  endtask

  initial begin
    #200us;
    $display("FAIL watchdog: got no finish, want finish before 200us");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; ps2_data = '0; ps2_data_en = 1'b0; row_sel = 8'hFF;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;

    check(8'hFE, 5'b11111, 1'b0, "rst_row0");
    check(8'h00, 5'b11111, 1'b0, "rst_all");
    check(8'hFF, 5'b11111, 1'b0, "rst_none");

    // Z make, exact two-edge latency
    @(posedge clk); #1;
    ps2_data = 8'h1A; ps2_data_en = 1'b1;
    @(posedge clk); #1;
    ps2_data_en = 1'b0;
    check(8'hFE, 5'b11111, 1'b0, "lat_n0");
    check(8'hFE, 5'b11111, 1'b0, "lat_n1");
    check(8'hFE, 5'b11101, 1'b1, "lat_n2");
    burst2(8'hF0, 8'h1A); settle();
    check(8'hFE, 5'b11111, 1'b0, "z_break_b2b");

    // SS held across "," press/release
    send(8'h59); settle();
    check(8'h7F, 5'b11101, 1'b1, "ss_held");
    send(8'h41); settle();
    check(8'h7F, 5'b10101, 1'b1, "comma_held");
    send(8'hF0); send(8'h41); settle();
    check(8'h7F, 5'b11101, 1'b1, "comma_rel_ss_kept");
    send(8'hF0); send(8'h59); settle();
    check(8'h7F, 5'b11111, 1'b0, "ss_rel");

    // typematic and stray break
    send(8'h1A); send(8'h1A); send(8'h1A); send(8'hF0); send(8'h1A); settle();
    check(8'hFE, 5'b11111, 1'b0, "typematic");
    send(8'hF0); send(8'h22); settle();
    check(8'hFE, 5'b11111, 1'b0, "break_not_held");

    // extended arrow
    send(8'hE0); send(8'h6B); settle();
    check(8'hF7, 5'b01111, 1'b1, "left_row3");
    check(8'hFE, 5'b11110, 1'b1, "left_row0");
    send(8'hE0); send(8'hF0); send(8'h6B); settle();
    check(8'hF7, 5'b11111, 1'b0, "left_rel_row3");
    check(8'hFE, 5'b11111, 1'b0, "left_rel_row0");
    send(8'hE0); send(8'h1A); settle();
    check(8'hFE, 5'b11111, 1'b0, "ext_nonext_ignored");

    // multi-row selection
    send(8'h1C); send(8'h15); settle();
    check(8'hFA, 5'b11110, 1'b1, "rows02_q");
    check(8'hF8, 5'b11110, 1'b1, "rows012");
    check(8'hFD, 5'b11110, 1'b1, "row1_a");
    check(8'hFF, 5'b11111, 1'b1, "no_rows");
    send(8'hF0); send(8'h15); settle();
    check(8'hFA, 5'b11111, 1'b1, "rows02_a_desel");
    check(8'hF8, 5'b11110, 1'b1, "rows012_a");
    send(8'hF0); send(8'h1C); settle();
    check(8'hFD, 5'b11111, 1'b0, "a_rel");

    // prefix timeout
    send(8'hF0);
    repeat (TMO + 6) @(posedge clk);
    send(8'h1C); settle();
    check(8'hFD, 5'b11110, 1'b1, "timeout_make");
    send(8'hF0); send(8'h1C); settle();
    check(8'hFD, 5'b11111, 1'b0, "no_timeout_break");

    // pause sequence
    send(8'h1A);
    send(8'hE1); send(8'h14); send(8'h77); settle();
    check(8'hFE, 5'b11101, 1'b1, "pause_mid");
    send(8'hE1); send(8'hF0); send(8'h14); send(8'hF0); send(8'h77);
    send(8'h1D); settle();
    check(8'hFB, 5'b11101, 1'b1, "after_pause_w");
    check(8'hFE, 5'b11101, 1'b1, "after_pause_z");
    send(8'hAA); settle();
    check(8'h00, 5'b11111, 1'b0, "aa_clear");

    // backspace, then error byte clears
    send(8'h66); settle();
    check(8'hFE, 5'b11110, 1'b1, "bs_cs");
    check(8'hEF, 5'b11110, 1'b1, "bs_0");
    send(8'hFF); settle();
    check(8'h00, 5'b11111, 1'b0, "ff_clear");

    // reset mid-sequence
    send(8'h1A); send(8'hF0);
    @(posedge clk); #1 reset = 1'b1;
    @(posedge clk); #1 reset = 1'b0;
    check(8'hFE, 5'b11111, 1'b0, "reset_clears");
    send(8'h1C); settle();
    check(8'hFD, 5'b11110, 1'b1, "reset_then_make");

    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clk);
    if (exp_q.size() > 0) begin
      n_total++;
      n_bad++;
      $display("FAIL drain: got %0d pending, want 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
